hc_wide_add_sequencer: RTL
==========================

# hc_wide_add_sequencer

Multi-cycle wide-operand adder controller that reuses a single WORD_W-bit Han-Carlson adder to add two NUM_WORDS×WORD_W-bit operands, one limb per cycle, least significant limb first. The carry is chained through a register. The block sits between an upstream producer and a downstream consumer, with a valid/ready handshake on each side. It is the sequencing layer that lets the narrow parallel-prefix adder serve wide arithmetic without replicating it.

## Interface
- WORD_W, 16, limb width; equals the width of the instantiated adder.
- NUM_WORDS, 4, limbs per operand; must be ≥ 2.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  operands and carry-in are presented.
- in_ready  out  1  block can accept operands; high only in IDLE.
- in_a  in  WORD_W*NUM_WORDS  operand A.
- in_b  in  WORD_W*NUM_WORDS  operand B.
- in_cin  in  1  carry into limb 0.
- in_sub  in  1  subtract request; present only with HCAS_SUB_EN.
- out_valid  out  1  result is held on out_sum/out_cout.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WORD_W*NUM_WORDS  wide sum, modulo 2^(WORD_W*NUM_WORDS).
- out_cout  out  1  carry out of the most significant limb.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. When in_valid is high at a clock edge, the block:
  - captures in_a and in_b into shift registers;
  - loads carry_q with in_cin;
  - clears limb index idx to 0;
  - moves to RUN.
- RUN: the adder receives a_q[idx], b_q[idx] and carry_q. At each edge, the limb sum is written to sum_q[idx], carry_q takes the adder cout, and idx increments. When idx == NUM_WORDS-1 at the edge, the FSM moves to DONE and out_cout takes the final carry.
- DONE: out_valid=1. out_sum and out_cout stay stable until out_ready is high at an edge; the FSM then returns to IDLE.
- Operands are not accepted in RUN or DONE. There is no back-to-back overlap.
- Widths: idx is $clog2(NUM_WORDS) bits. The carry chain is exactly 1 bit per limb. No saturation: the sum wraps.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out_sum=0, out_cout=0, idx=0, carry_q=0.
- Reset mid-operation, in RUN or DONE: the next cycle is IDLE and the pending result is discarded, with no out_valid pulse. Reset takes priority over in_valid and out_ready in the same cycle.
- in_valid while not in IDLE is ignored. The upstream side holds its data until it sees in_ready.

## Timing
- Accept edge T0. Limbs are registered at edges T1..T_NUM_WORDS. out_valid rises after edge T_NUM_WORDS (latency NUM_WORDS cycles, which is 4 at the defaults).
- The earliest re-accept is the edge after the out handshake, because in_ready rises in the cycle following it. Minimum initiation interval is NUM_WORDS+2 cycles.
- The critical path is one WORD_W-bit adder plus the carry_q mux. There is no wide combinational path.
- The outputs in_ready, out_valid and busy are decoded from registers only.

## Configuration
- HCAS_SUB_EN defined:
  - the in_sub port exists;
  - at accept with in_sub=1, b_q captures ~in_b and carry_q is loaded with 1 (in_cin is ignored), so the block computes A−B;
  - out_cout=1 means no borrow.
- HCAS_SUB_EN undefined: the in_sub port is absent and the block only adds.

## Structure
- Shared package hcas_pkg holds:
  - the state_t enum (IDLE, RUN, DONE);
  - default constants HCAS_WORD_W=16 and HCAS_NUM_WORDS=4.
- One sub-module: the existing han_carlson_adder (a, b, cin, sum, cout), instantiated once as the limb datapath.
- The FSM, limb shift registers and result assembly live in hc_wide_add_sequencer.

## Test plan
- Single limb carry: A=0x0000_0000_0000_FFFF, B=0x1, cin=0 → out_sum=0x0000_0000_0001_0000, out_cout=0. out_valid is high exactly 4 cycles after the accept edge.
- Full carry ripple: A=0xFFFF_FFFF_FFFF_FFFF, B=0, cin=1 → out_sum=0, out_cout=1.
- Max operands: A=B=0xFFFF_FFFF_FFFF_FFFF, cin=1 → out_sum=0xFFFF_FFFF_FFFF_FFFF, out_cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid, out_sum and out_cout are stable and in_ready=0. Then pulse out_ready → in_ready=1 the next cycle, and a second operand set is accepted with the correct result.
- Reset mid-RUN: assert rst on the 2nd RUN cycle → the next cycle has state IDLE, out_valid=0, in_ready=1, out_sum=0, and no result is emitted.
- HCAS_SUB_EN: A=0x10, B=0x11, in_sub=1 → out_sum=0xFFFF_FFFF_FFFF_FFFF, out_cout=0. A=0x11, B=0x10 → out_sum=0x1, out_cout=1.

Source files
------------

// File: rtl/hcas_pkg.sv
// Shared definitions for the wide-operand Han-Carlson add sequencer:
// FSM state encoding and the default limb geometry.
package hcas_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int HCAS_WORD_W    = 16;
    localparam int HCAS_NUM_WORDS = 4;

endpackage : hcas_pkg

// File: rtl/han_carlson_adder.sv
// WIDTH-bit Han-Carlson parallel-prefix adder (a + b + cin).
// Odd bit positions resolve their group generate through a Kogge-Stone
// tree at half density; even positions are fixed up by one final
// combine stage with their odd neighbour.
module han_carlson_adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] p0;
    logic [WIDTH-1:0] g0;
    logic [WIDTH-1:0] grp;
    logic [WIDTH-1:0] c;

    // Group generate G[i:0] for every bit, with cin folded into bit 0.
    function automatic logic [WIDTH-1:0] hc_group_gen(
        input logic [WIDTH-1:0] g_in,
        input logic [WIDTH-1:0] p_in
    );
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g_n;
        logic [WIDTH-1:0] p_n;
        logic [WIDTH-1:0] res;
        g = g_in;
        p = p_in;
        // Odd bits absorb their even neighbour: span 2.
        g_n = g;
        p_n = p;
        for (int i = 1; i < WIDTH; i = i + 2) begin
            g_n[i] = g[i] | (p[i] & g[i-1]);
            p_n[i] = p[i] & p[i-1];
        end
        g = g_n;
        p = p_n;
        // Kogge-Stone over the odd bits only, doubling the span each level.
        for (int s = 2; s < WIDTH; s = s * 2) begin
            g_n = g;
            p_n = p;
            for (int i = 1; i < WIDTH; i = i + 2) begin
                if (i >= s) begin
                    g_n[i] = g[i] | (p[i] & g[i-s]);
                    p_n[i] = p[i] & p[i-s];
                end
            end
            g = g_n;
            p = p_n;
        end
        // Even bits close out against the finished odd bit below them.
        res = g;
        for (int i = 2; i < WIDTH; i = i + 2) begin
            res[i] = g[i] | (p[i] & g[i-1]);
        end
        return res;
    endfunction

    assign p0 = a ^ b;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign g0[gi] = (a[gi] & b[gi]) | (p0[gi] & cin);
                assign c[gi]  = cin;
            end else begin : g_upper
                assign g0[gi] = a[gi] & b[gi];
                assign c[gi]  = grp[gi-1];
            end
            assign sum[gi] = p0[gi] ^ c[gi];
        end
    endgenerate

    assign grp  = hc_group_gen(g0, p0);
    assign cout = grp[WIDTH-1];

endmodule : han_carlson_adder

// File: rtl/hc_wide_add_sequencer.sv
// Multi-cycle wide adder: pushes NUM_WORDS limbs, LSB first, through one
// WORD_W-bit Han-Carlson adder with a registered carry chain.
// Optional macro HCAS_SUB_EN adds the in_sub port for A-B operation.
module hc_wide_add_sequencer
    import hcas_pkg::*;
#(
    parameter int WORD_W    = HCAS_WORD_W,
    parameter int NUM_WORDS = HCAS_NUM_WORDS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WORD_W*NUM_WORDS-1:0] in_a,
    input  logic [WORD_W*NUM_WORDS-1:0] in_b,
    input  logic                        in_cin,
`ifdef HCAS_SUB_EN
    input  logic                        in_sub,
`endif
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WORD_W*NUM_WORDS-1:0] out_sum,
    output logic                        out_cout,
    output logic                        busy
);

    localparam int TOTAL_W = WORD_W * NUM_WORDS;
    localparam int IDX_W   = $clog2(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_t               state_reg;
    state_t               state_next;
    logic [TOTAL_W-1:0]   a_reg;
    logic [TOTAL_W-1:0]   b_reg;
    logic [TOTAL_W-1:0]   sum_reg;
    logic                 carry_reg;
    logic                 cout_reg;
    logic [IDX_W-1:0]     idx_reg;
    logic                 sub_sel;
    logic [WORD_W-1:0]    limb_sum;
    logic                 limb_cout;
    logic                 accept;
    logic                 last_limb;

`ifdef HCAS_SUB_EN
    assign sub_sel = in_sub;
`else
    assign sub_sel = 1'b0;
`endif

    assign accept    = (state_reg == IDLE) && in_valid;
    assign last_limb = (idx_reg == LAST_IDX);

    // Single limb datapath; operand registers shift right so limb idx is
    // always at the bottom and no wide index mux is needed.
    han_carlson_adder #(
        .WIDTH (WORD_W)
    ) u_limb_adder (
        .a    (a_reg[WORD_W-1:0]),
        .b    (b_reg[WORD_W-1:0]),
        .cin  (carry_reg),
        .sum  (limb_sum),
        .cout (limb_cout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_limb) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Handshake/status outputs, decoded from the state register only.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_reg)
            IDLE:    in_ready  = 1'b1;
            RUN:     busy      = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready  = 1'b0;
        endcase
    end

    // Operand capture, limb stepping and result assembly. The sum register
    // fills from the top so after NUM_WORDS steps limb 0 sits at the bottom.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            idx_reg   <= '0;
        end else if (accept) begin
            a_reg     <= in_a;
            b_reg     <= sub_sel ? ~in_b : in_b;
            carry_reg <= sub_sel ? 1'b1 : in_cin;
            idx_reg   <= '0;
        end else if (state_reg == RUN) begin
            a_reg     <= a_reg >> WORD_W;
            b_reg     <= b_reg >> WORD_W;
            sum_reg   <= {limb_sum, sum_reg[TOTAL_W-1:WORD_W]};
            carry_reg <= limb_cout;
            idx_reg   <= idx_reg + 1'b1;
            if (last_limb) begin
                cout_reg <= limb_cout;
            end
        end
    end

    assign out_sum  = sum_reg;
    assign out_cout = cout_reg;

endmodule : hc_wide_add_sequencer
